// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio gain stage.
//   gain_unity : value of unity gain for a Q1.(gain_w-1) unsigned gain word
//   sat_signed : clamp a signed value into the range of a width-bit signed word
//   ramp_step  : next ramped gain given current value, target and max step
package audio_pkg;

  function automatic int gain_unity(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  // Within one step of the target we land on it exactly, so the ramp never
  // overshoots or oscillates around a target that is not a step multiple.
  function automatic int ramp_step(input int cur, input int target, input int step);
    int diff;
    diff = target - cur;
    if (diff > step)       return cur + step;
    else if (diff < -step) return cur - step;
    else                   return target;
  endfunction

endpackage

// File: rtl/gain_sat_lane.sv
// One audio channel of the gain stage: multiply, round, saturate, clip detect.
//   clk_in, rst_n_in : clock and async active-low reset
//   en_mul_in        : register the product of sample_in and gain_in
//   en_out_in        : register the rounded/saturated result (product stage valid)
//   clip_clr_in      : clear the sticky clip flag (a new clip in the same cycle wins)
//   sample_in        : signed input sample
//   gain_in          : unsigned Q1.(GAIN_W-1) gain
//   sample_out       : scaled sample, held between strobes
//   clip_out         : sticky saturation flag
module gain_sat_lane
  import audio_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int GAIN_W = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    en_mul_in,
  input  logic                    en_out_in,
  input  logic                    clip_clr_in,
  input  logic [WIDTH-1:0]        sample_in,
  input  logic [GAIN_W-1:0]       gain_in,
  output logic [WIDTH-1:0]        sample_out,
  output logic                    clip_out
);

  localparam int P_W = WIDTH + GAIN_W + 1;

  logic signed [P_W-1:0]   a_ext;
  logic signed [P_W-1:0]   g_ext;
  logic signed [P_W-1:0]   p_d, p_q;
  logic signed [P_W:0]     sum;
  logic signed [P_W:0]     r;
  logic signed [63:0]      r_ext;
  logic signed [63:0]      s_ext;
  logic                    sat;
  logic [WIDTH-1:0]        sample_d, sample_q;
  logic                    clip_d, clip_q;

  localparam logic signed [P_W:0] ROUND_C = (P_W+1)'(2 ** (GAIN_W - 2));

  always_comb begin
    // Gain is unsigned; a zero MSB keeps it positive in the signed multiply.
    a_ext = P_W'($signed(sample_in));
    g_ext = P_W'($signed({1'b0, gain_in}));
    p_d   = en_mul_in ? (a_ext * g_ext) : p_q;

    // Round half up, then drop the fractional gain bits.
    sum   = (P_W+1)'(p_q) + ROUND_C;
    r     = sum >>> (GAIN_W - 1);
    r_ext = 64'(r);
    s_ext = sat_signed(r_ext, WIDTH);
    sat   = (s_ext != r_ext);

    sample_d = en_out_in ? WIDTH'(s_ext) : sample_q;

    clip_d = clip_q;
    if (clip_clr_in)          clip_d = 1'b0;
    if (en_out_in && sat)     clip_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      p_q      <= '0;
      sample_q <= '0;
      clip_q   <= 1'b0;
    end else begin
      p_q      <= p_d;
      sample_q <= sample_d;
      clip_q   <= clip_d;
    end
  end

  assign sample_out = sample_q;
  assign clip_out   = clip_q;

endmodule

// File: rtl/audio_gain_ramp.sv
// Multi-channel fractional gain stage with per-sample gain ramping and mute.
//   clk_in, rst_n_in : clock; reset asserts asynchronously, releases synchronously
//   gain_in          : target gain, unsigned Q1.(GAIN_W-1)
//   mute_in          : forces the target to 0 (ramps down)
//   clip_clr_in      : clears all sticky clip flags
//   sample_in        : NUM_CH packed signed samples, ch0 in the LSBs
//   valid_in         : single-cycle sample strobe
//   sample_out       : scaled, saturated samples (held between strobes)
//   valid_out        : valid_in delayed by two cycles
//   clip_out         : sticky per-channel saturation flags
//   gain_cur_out     : current ramped gain
//   ramp_busy_out    : current gain differs from the effective target
// Handshake: valid_in/valid_out are one-cycle strobes with no back-pressure;
// every strobed sample vector emerges exactly two cycles later.
module audio_gain_ramp
  import audio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_CH    = 2,
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [GAIN_W-1:0]       gain_in,
  input  logic                    mute_in,
  input  logic                    clip_clr_in,
  input  logic [NUM_CH*WIDTH-1:0] sample_in,
  input  logic                    valid_in,
  output logic [NUM_CH*WIDTH-1:0] sample_out,
  output logic                    valid_out,
  output logic [NUM_CH-1:0]       clip_out,
  output logic [GAIN_W-1:0]       gain_cur_out,
  output logic                    ramp_busy_out
);

  // Reset synchroniser: the core sees reset immediately, but release is
  // aligned to the clock so no flop leaves reset on a partial edge.
  logic [1:0] rst_sync_d, rst_sync_q;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_q <= '0;
    else           rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  // Ramp controller and valid pipeline.
  logic [GAIN_W-1:0] target;
  logic [GAIN_W-1:0] gain_cur_d, gain_cur_q;
  logic              busy_d, busy_q;
  logic              v1_d, v1_q;
  logic              vout_d, vout_q;

  always_comb begin
    target = mute_in ? '0 : gain_in;
    // The lanes multiply by gain_cur_q, i.e. the gain before this edge's step.
    gain_cur_d = gain_cur_q;
    if (valid_in)
      gain_cur_d = GAIN_W'(ramp_step(int'(gain_cur_q), int'(target), RAMP_STEP));
    busy_d = (gain_cur_d != target);
    v1_d   = valid_in;
    vout_d = v1_q;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gain_cur_q <= '0;
      busy_q     <= 1'b0;
      v1_q       <= 1'b0;
      vout_q     <= 1'b0;
    end else begin
      gain_cur_q <= gain_cur_d;
      busy_q     <= busy_d;
      v1_q       <= v1_d;
      vout_q     <= vout_d;
    end
  end

  // Per-channel datapath.
  logic [WIDTH-1:0] lane_out [NUM_CH];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    gain_sat_lane #(
      .WIDTH  (WIDTH),
      .GAIN_W (GAIN_W)
    ) u_lane (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n),
      .en_mul_in   (valid_in),
      .en_out_in   (v1_q),
      .clip_clr_in (clip_clr_in),
      .sample_in   (sample_in[ch*WIDTH +: WIDTH]),
      .gain_in     (gain_cur_q),
      .sample_out  (lane_out[ch]),
      .clip_out    (clip_out[ch])
    );
  end

  always_comb begin
    sample_out = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      sample_out[ch*WIDTH +: WIDTH] = lane_out[ch];
  end

  assign valid_out     = vout_q;
  assign gain_cur_out  = gain_cur_q;
  assign ramp_busy_out = busy_q;

endmodule

// File: tb/tb_audio_gain_ramp.sv
// Bench for audio_gain_ramp (WIDTH=8, NUM_CH=2, GAIN_W=8, RAMP_STEP=4).
module tb_audio_gain_ramp;

  // ---------------- clock / reset ----------------
  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [7:0]  gain_in;
  logic        mute_in;
  logic        clip_clr_in;
  logic [15:0] sample_in;
  logic        valid_in;
  logic [15:0] sample_out;
  logic        valid_out;
  logic [1:0]  clip_out;
  logic [7:0]  gain_cur_out;
  logic        ramp_busy_out;

  always #5 clk_in = ~clk_in;

  audio_gain_ramp #(
    .WIDTH(8), .NUM_CH(2), .GAIN_W(8), .RAMP_STEP(4)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .gain_in       (gain_in),
    .mute_in       (mute_in),
    .clip_clr_in   (clip_clr_in),
    .sample_in     (sample_in),
    .valid_in      (valid_in),
    .sample_out    (sample_out),
    .valid_out     (valid_out),
    .clip_out      (clip_out),
    .gain_cur_out  (gain_cur_out),
    .ramp_busy_out (ramp_busy_out)
  );

  int          checks = 0;
  int          failures = 0;
  int          model_gain = 0;
  logic [15:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic int ramp_m(input int cur, input int tgt);
    if (tgt > cur) return (tgt - cur <= 4) ? tgt : cur + 4;
    else           return (cur - tgt <= 4) ? tgt : cur - 4;
  endfunction

  // Floor of (s*g + 64)/128, clamped to 8-bit signed.
  function automatic logic [7:0] scale_m(input logic [7:0] s, input int g);
    int num;
    int q;
    num = int'($signed(s)) * g + 64;
    q = num / 128;
    if ((num < 0) && ((num % 128) != 0)) q = q - 1;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_valid(input logic [7:0] c0, input logic [7:0] c1);
    sample_in = {c1, c0};
    valid_in  = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in  = 1'b0;
    model_gain = ramp_m(model_gain, mute_in ? 0 : int'(gain_in));
  endtask

  task automatic send(input logic [7:0] c0, input logic [7:0] c1);
    exp_q.push_back({scale_m(c1, model_gain), scale_m(c0, model_gain)});
    do_valid(c0, c1);
  endtask

  task automatic send_exp(input logic [7:0] c0, input logic [7:0] c1, input logic [15:0] e);
    exp_q.push_back(e);
    do_valid(c0, c1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic ramp_to(input int tgt);
    for (int i = 0; i < 80 && model_gain != tgt; i++) send(8'd0, 8'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_in) begin
    if (rst_n_in && valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid_out sample_out=%h", sample_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (sample_out !== e) begin
          failures++;
          $display("FAIL sample_out actual=%h expected=%h", sample_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int vcount;
    logic [7:0] ramp_tbl [5];
    ramp_tbl[0] = 8'd56; ramp_tbl[1] = 8'd52; ramp_tbl[2] = 8'd48;
    ramp_tbl[3] = 8'd44; ramp_tbl[4] = 8'd40;

    rst_n_in = 1'b0; gain_in = 8'd0; mute_in = 1'b0; clip_clr_in = 1'b0;
    sample_in = '0; valid_in = 1'b0;

    // 1: reset state, soft-start ramp to unity
    idle(3);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_clip_out", int'(clip_out), 0);
    chk("rst_gain_cur", int'(gain_cur_out), 0);
    chk("rst_busy", int'(ramp_busy_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    idle(4);
    gain_in = 8'd128;
    for (int i = 1; i <= 40; i++) begin
      send(8'd100, 8'd0);
      if (i == 1)  chk("ramp_gain_1", int'(gain_cur_out), 4);
      if (i == 31) chk("ramp_gain_31", int'(gain_cur_out), 124);
      if (i == 32) chk("ramp_gain_32", int'(gain_cur_out), 128);
    end
    idle(3);
    chk("unity_out_100", int'(sample_out), 16'h0064);
    chk("unity_busy", int'(ramp_busy_out), 0);

    // 2: latency, negative full scale at unity, rounding per channel
    send_exp(8'h80, 8'd0, 16'h0080);
    @(negedge clk_in); chk("latency_cycle1", int'(valid_out), 0);
    @(negedge clk_in); chk("latency_cycle2", int'(valid_out), 1);
    @(negedge clk_in); chk("latency_single", int'(valid_out), 0);
    idle(1);
    chk("neg_unity_clip", int'(clip_out), 0);
    gain_in = 8'd64;
    ramp_to(64);
    chk("gain_64", int'(gain_cur_out), 64);
    send_exp(8'd100, 8'hCE, 16'hE732);
    send_exp(8'hCE, 8'd100, 16'h32E7);
    idle(3);

    // 3: saturation and sticky clip
    gain_in = 8'd255;
    ramp_to(255);
    chk("gain_255", int'(gain_cur_out), 255);
    send_exp(8'd100, 8'd0, 16'h007F);
    idle(2);
    chk("clip_set_ch0", int'(clip_out), 1);
    send_exp(8'd10, 8'hF6, 16'hEC14);
    idle(2);
    chk("clip_sticky", int'(clip_out), 1);
    clip_clr_in = 1'b1;
    idle(1);
    clip_clr_in = 1'b0;
    chk("clip_cleared", int'(clip_out), 0);
    send_exp(8'd0, 8'h9C, 16'h8000);
    clip_clr_in = 1'b1;
    idle(1);
    clip_clr_in = 1'b0;
    idle(1);
    chk("clip_set_wins", int'(clip_out), 2);
    clip_clr_in = 1'b1;
    idle(1);
    clip_clr_in = 1'b0;
    idle(2);

    // 4: mute ramp down, unmute, frozen during gaps
    gain_in = 8'd128;
    ramp_to(128);
    chk("gain_back_128", int'(gain_cur_out), 128);
    mute_in = 1'b1;
    for (int i = 0; i < 32; i++) send(8'd100, 8'h9C);
    chk("mute_gain_0", int'(gain_cur_out), 0);
    send_exp(8'h9C, 8'hFF, 16'h0000);
    send_exp(8'h80, 8'h7F, 16'h0000);
    mute_in = 1'b0;
    for (int i = 0; i < 5; i++) send(8'd100, 8'h9C);
    chk("unmute_gain_20", int'(gain_cur_out), 20);
    idle(10);
    chk("gap_frozen", int'(gain_cur_out), 20);
    chk("gap_busy", int'(ramp_busy_out), 1);
    for (int i = 0; i < 40 && model_gain != 128; i++) send(8'd100, 8'h9C);
    chk("unmute_gain_128", int'(gain_cur_out), 128);
    chk("unmute_busy", int'(ramp_busy_out), 0);

    // 5: redirect mid-ramp
    mute_in = 1'b1;
    ramp_to(0);
    mute_in = 1'b0;
    for (int i = 0; i < 15; i++) send(8'd50, 8'hB0);
    chk("redirect_start_60", int'(gain_cur_out), 60);
    chk("redirect_start_busy", int'(ramp_busy_out), 1);
    gain_in = 8'd40;
    for (int i = 0; i < 5; i++) begin
      send(8'd50, 8'hB0);
      chk($sformatf("redirect_gain_%0d", i), int'(gain_cur_out), int'(ramp_tbl[i]));
      chk($sformatf("redirect_busy_%0d", i), int'(ramp_busy_out), (i < 4) ? 1 : 0);
    end
    idle(3);

    // 6: async reset mid-stream
    for (int i = 0; i < 3; i++) send(8'd100, 8'd100);
    sample_in = {8'd100, 8'd100};
    valid_in  = 1'b1;
    @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    #1;
    chk("arst_valid_out", int'(valid_out), 0);
    chk("arst_sample_out", int'(sample_out), 0);
    chk("arst_gain_cur", int'(gain_cur_out), 0);
    exp_q.delete();
    model_gain = 0;
    valid_in = 1'b0;
    idle(2);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (valid_out) vcount++;
    end
    chk("no_stale_valid", vcount, 0);
    chk("post_rst_gain", int'(gain_cur_out), 0);

    // drain and report
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
